// File: rtl/serial_shifter_if.sv
// Request/response bundle for serial_shifter: operand, shift amount and op in,
// shifted result out, with independent valid/ready handshakes on each side.
interface serial_shifter_if #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = $clog2(WIDTH)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       data;
  logic [SHIFT_WIDTH-1:0] shift;
  logic [2:0]             op;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       result;
  logic                   err;

  modport master (
    output in_valid, data, shift, op, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, data, shift, op, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/serial_shifter.sv
// Multi-cycle shifter/rotator: moves the operand by at most STEP bit positions
// per cycle until the requested amount is consumed, then holds the result.
module serial_shifter #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = $clog2(WIDTH),
  parameter int STEP        = 4
) (
  input logic            clk,
  input logic            rst,
  serial_shifter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_LSL = 3'b000, OP_ASL = 3'b001, OP_LSR = 3'b010,
    OP_ASR = 3'b011, OP_ROL = 3'b100, OP_ROR = 3'b101
  } op_e;

  localparam logic [SHIFT_WIDTH:0] STEP_W  = (SHIFT_WIDTH+1)'(STEP);
  localparam logic [SHIFT_WIDTH:0] WIDTH_W = (SHIFT_WIDTH+1)'(WIDTH);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       work_q, work_d;
  logic [SHIFT_WIDTH-1:0] rem_q, rem_d;
  logic [2:0]             op_q, op_d;
  logic                   sign_q, sign_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   err_q, err_d;

  logic [SHIFT_WIDTH-1:0] amt;
  logic [SHIFT_WIDTH:0]   back;
  logic [WIDTH-1:0]       step_val;
  logic                   op_invalid;

  assign op_invalid = bus.op[2] & bus.op[1];

  // One step of the captured operation on the working register.
  always_comb begin
    amt  = ({1'b0, rem_q} > STEP_W) ? STEP_W[SHIFT_WIDTH-1:0] : rem_q;
    back = WIDTH_W - {1'b0, amt};
    case (op_q)
      OP_LSL, OP_ASL: step_val = work_q << amt;
      OP_LSR:         step_val = work_q >> amt;
      OP_ASR:         step_val = (work_q >> amt) | (sign_q ? ~({WIDTH{1'b1}} >> amt) : '0);
      OP_ROL:         step_val = (work_q << amt) | (work_q >> back);
      OP_ROR:         step_val = (work_q >> amt) | (work_q << back);
      default:        step_val = work_q;
    endcase
  end

  // NOTE: every next-state signal takes its hold value first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    op_d     = op_q;
    sign_d   = sign_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.data;
          rem_d  = bus.shift;
          op_d   = bus.op;
          sign_d = bus.data[WIDTH-1];
          if (op_invalid || bus.shift == '0) begin
            // Nothing to shift: the operand itself is the result.
            result_d = bus.data;
            err_d    = op_invalid;
            state_d  = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = step_val;
        rem_d  = rem_q - amt;
        if (rem_d == '0) begin
          result_d = step_val;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and clears all registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Randomized self-checking bench for serial_shifter against an arithmetic
// reference model of the shift/rotate operations and their latency.
module tb_serial_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_shifter_if #(.WIDTH(WIDTH)) bus ();

  serial_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {err, result} from the operation definitions.
  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] d,
                                        input logic [4:0] s);
    logic [63:0] dd, tmp;
    logic [31:0] r;
    dd = {d, d};
    case (op)
      3'd0, 3'd1: r = d << s;
      3'd2:       r = d >> s;
      3'd3:       r = $signed(d) >>> s;
      3'd4:       begin tmp = dd << s; r = tmp[63:32]; end
      3'd5:       begin tmp = dd >> s; r = tmp[31:0];  end
      default:    r = d;
    endcase
    return {(op >= 3'd6), r};
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [4:0] s);
    if (op >= 3'd6 || s == 0) return 1;
    return 1 + (int'(s) + STEP - 1) / STEP;
  endfunction

  task automatic do_req(input string name, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] s, input int hold);
    logic [32:0] exp_v;
    int          lat;
    int          waited;
    exp_v = model(op, d, s);
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data     = d;
    bus.shift    = s;
    bus.op       = op;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check({name, "_ready_timeout"}, 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data     = $urandom;
    bus.shift    = 5'($urandom);
    bus.op       = 3'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    check({name, "_latency"}, 64'(lat), 64'(model_lat(op, s)));
    check({name, "_result"}, 64'(bus.result), 64'(exp_v[31:0]));
    check({name, "_err"}, 64'(bus.err), 64'(exp_v[32]));
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_hold_result"}, 64'(bus.result), 64'(exp_v[31:0]));
        check({name, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check({name, "_idle_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({name, "_idle_valid"}, {63'd0, bus.out_valid, bus.err}, 64'd0);
    check({name, "_idle_result_held"}, 64'(bus.result), 64'(exp_v[31:0]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    bus.in_valid  = 1'b0;
    bus.data      = '0;
    bus.shift     = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'd0);
    check("reset_outputs", {31'd0, bus.out_valid, bus.err, bus.result}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    do_req("lsr5",    3'b010, 32'hF000_0000, 5'd5,  0);
    do_req("asr31",   3'b011, 32'h8000_0000, 5'd31, 0);
    do_req("lsr31",   3'b010, 32'h8000_0000, 5'd31, 0);
    do_req("rol4",    3'b100, 32'h8000_0001, 5'd4,  0);
    do_req("ror4",    3'b101, 32'h0000_0018, 5'd4,  0);
    do_req("lsl0",    3'b000, 32'h1234_5678, 5'd0,  0);
    do_req("badop",   3'b111, 32'h1234_5678, 5'd9,  0);
    do_req("backpr",  3'b001, 32'h0000_00FF, 5'd7,  3);

    // Reset in the middle of a long arithmetic shift.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data     = 32'h8000_0000;
    bus.shift    = 5'd31;
    bus.op       = 3'b011;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midop_busy_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midop_rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midop_after_outputs", {31'd0, bus.out_valid, bus.err, bus.result}, 64'd0);
    check("midop_after_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    check("midop_no_valid_pulse", 64'(seen), 64'd0);
    do_req("after_rst", 3'b011, 32'h8000_0000, 5'd31, 0);

    for (int i = 0; i < 40; i++) begin
      do_req($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
